// File: rtl/memload_pkg.sv
// Shared types and constants for the memory-stage load unit.
// Optional split-load support is selected with MEMLOAD_SPLIT_EN.
package memload_pkg;

    localparam int QWORD_BYTES = 8;

    typedef enum logic [1:0] {
        B1 = 2'd0,
        B2 = 2'd1,
        B4 = 2'd2,
        B8 = 2'd3
    } ld_size_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5,
        S_DRAIN = 3'd6
    } memload_state_t;

    function automatic logic [3:0] size_bytes(input ld_size_t size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/memload_if.sv
// Data-memory read port between the load unit (master) and memory (slave).
interface memload_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/mod_load_align.sv
// Combinational byte extraction and sign/zero extension from two quadwords.
module mod_load_align
    import memload_pkg::*;
(
    input  logic [127:0] i_data,
    input  logic [2:0]   i_off,
    input  ld_size_t     i_size,
    input  logic         i_signed,
    output logic [63:0]  o_data
);
    logic [63:0] w_low;

    // Select the addressed bytes and extend them to 64 bits.
    always_comb begin
        w_low = i_data[{i_off, 3'b000} +: 64];
        case (i_size)
            B1:      o_data = {{56{i_signed & w_low[7]}},  w_low[7:0]};
            B2:      o_data = {{48{i_signed & w_low[15]}}, w_low[15:0]};
            B4:      o_data = {{32{i_signed & w_low[31]}}, w_low[31:0]};
            B8:      o_data = w_low;
            default: o_data = w_low;
        endcase
    end
endmodule

// File: rtl/mod_memload.sv
// Memory-stage load unit: one or two aligned reads, merge, extract, extend.
// Define MEMLOAD_SPLIT_EN to support quadword-crossing loads; otherwise they fault.
module mod_memload
    import memload_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic              flush,
    output logic              ld_busy,
    output logic              load_done,
    output logic [63:0]       load_buffer,
    output logic              ld_fault,
    memload_if.master         mem
);
    memload_state_t    r_state;
    logic [2:0]        r_off;
    ld_size_t          r_size;
    logic              r_signed;
    logic              r_cross;
    logic [DATA_W-1:0] r_q0;
    logic              r_busy;
    logic              r_load_done;
    logic              r_ld_fault;
    logic [63:0]       r_load_buffer;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] w_q1;
    logic [63:0]       w_aligned;

`ifdef MEMLOAD_SPLIT_EN
    logic [DATA_W-1:0] r_q1;
    assign w_q1 = r_q1;
`else
    assign w_q1 = {DATA_W{1'b0}};
`endif

    mod_load_align u_align (
        .i_data   ({w_q1, r_q0}),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_aligned)
    );

    // Load FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_off         <= 3'd0;
            r_size        <= B1;
            r_signed      <= 1'b0;
            r_cross       <= 1'b0;
            r_q0          <= {DATA_W{1'b0}};
            r_busy        <= 1'b0;
            r_load_done   <= 1'b0;
            r_ld_fault    <= 1'b0;
            r_load_buffer <= 64'd0;
            r_req_valid   <= 1'b0;
            r_req_addr    <= {ADDR_W{1'b0}};
`ifdef MEMLOAD_SPLIT_EN
            r_q1          <= {DATA_W{1'b0}};
`endif
        end else begin
            r_load_done <= 1'b0;
            r_ld_fault  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ld_start && !flush) begin
                        r_off       <= ld_addr[2:0];
                        r_size      <= ld_size_t'(ld_size);
                        r_signed    <= ld_signed;
                        r_cross     <= ({1'b0, ld_addr[2:0]} + size_bytes(ld_size_t'(ld_size))) > 4'(QWORD_BYTES);
                        r_req_addr  <= {ld_addr[ADDR_W-1:3], 3'b000};
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_REQ0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ0: begin
                    if (flush) begin
                        r_req_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (mem.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT0;
                    end else begin
                        r_state <= S_REQ0;
                    end
                end
                S_WAIT0: begin
                    // A response in the flush cycle is the one being drained.
                    if (flush) begin
                        r_busy  <= !mem.mem_resp_valid;
                        r_state <= mem.mem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (mem.mem_resp_valid) begin
                        r_q0 <= mem.mem_resp_data;
`ifdef MEMLOAD_SPLIT_EN
                        if (r_cross) begin
                            r_req_addr  <= r_req_addr + {{(ADDR_W-4){1'b0}}, 4'd8};
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ1;
                        end else begin
                            r_state <= S_DONE;
                        end
`else
                        r_state <= S_DONE;
`endif
                    end else begin
                        r_state <= S_WAIT0;
                    end
                end
`ifdef MEMLOAD_SPLIT_EN
                S_REQ1: begin
                    if (flush) begin
                        r_req_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (mem.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT1;
                    end else begin
                        r_state <= S_REQ1;
                    end
                end
                S_WAIT1: begin
                    if (flush) begin
                        r_busy  <= !mem.mem_resp_valid;
                        r_state <= mem.mem_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (mem.mem_resp_valid) begin
                        r_q1    <= mem.mem_resp_data;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT1;
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (flush) begin
                        r_load_done <= 1'b0;
`ifndef MEMLOAD_SPLIT_EN
                    end else if (r_cross) begin
                        r_ld_fault <= 1'b1;
`endif
                    end else begin
                        r_load_buffer <= w_aligned;
                        r_load_done   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mem.mem_resp_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign ld_busy           = r_busy;
    assign load_done         = r_load_done;
    assign load_buffer       = r_load_buffer;
    assign ld_fault          = r_ld_fault;
    assign mem.mem_req_valid = r_req_valid;
    assign mem.mem_req_addr  = r_req_addr;
endmodule

// File: tb/tb_mod_memload.sv
// Directed self-checking bench for mod_memload; follows MEMLOAD_SPLIT_EN.
module tb_mod_memload;
    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start;
    logic [63:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic        flush;
    logic        ld_busy;
    logic        load_done;
    logic [63:0] load_buffer;
    logic        ld_fault;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_buf;

    memload_if #(.ADDR_W(64), .DATA_W(64)) mem_bus ();

    mod_memload #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_start    (ld_start),
        .ld_addr     (ld_addr),
        .ld_size     (ld_size),
        .ld_signed   (ld_signed),
        .flush       (flush),
        .ld_busy     (ld_busy),
        .load_done   (load_done),
        .load_buffer (load_buffer),
        .ld_fault    (ld_fault),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [63:0] a, input logic [1:0] s, input logic sg);
        ld_start  = 1'b1;
        ld_addr   = a;
        ld_size   = s;
        ld_signed = sg;
        tick();
        ld_start  = 1'b0;
    endtask

    task automatic respond(input logic [63:0] d);
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_data  = d;
        tick();
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data  = 64'd0;
    endtask

    initial begin
        reset = 1'b0; ld_start = 1'b0; ld_addr = 64'd0; ld_size = 2'd0;
        ld_signed = 1'b0; flush = 1'b0;
        mem_bus.mem_req_ready = 1'b1; mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data = 64'd0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_busy", {63'd0, ld_busy}, 64'd0);
        check("rst_done", {63'd0, load_done}, 64'd0);
        check("rst_fault", {63'd0, ld_fault}, 64'd0);
        check("rst_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        check("rst_buf", load_buffer, 64'd0);

        // 1B signed at 0x1007: done three edges after the start edge
        start(64'h1007, 2'd0, 1'b1);
        check("t1_valid", {63'd0, mem_bus.mem_req_valid}, 64'd1);
        check("t1_addr", mem_bus.mem_req_addr, 64'h1000);
        check("t1_busy", {63'd0, ld_busy}, 64'd1);
        tick();
        check("t1_wait_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        respond(64'h8000_0000_0000_0000);
        check("t1_early_done", {63'd0, load_done}, 64'd0);
        tick();
        check("t1_done", {63'd0, load_done}, 64'd1);
        check("t1_buf", load_buffer, 64'hFFFF_FFFF_FFFF_FF80);
        check("t1_idle", {63'd0, ld_busy}, 64'd0);
        tick();
        check("t1_pulse", {63'd0, load_done}, 64'd0);

        // 4B unsigned at 0x2004
        start(64'h2004, 2'd2, 1'b0);
        check("t2_addr", mem_bus.mem_req_addr, 64'h2000);
        tick();
        respond(64'hDEAD_BEEF_1122_3344);
        check("t2_one_req", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        tick();
        check("t2_done", {63'd0, load_done}, 64'd1);
        check("t2_buf", load_buffer, 64'h0000_0000_DEAD_BEEF);
        exp_buf = 64'h0000_0000_DEAD_BEEF;
        tick();

        // 8B crossing load at 0x3005
        start(64'h3005, 2'd3, 1'b0);
        check("t3_addr0", mem_bus.mem_req_addr, 64'h3000);
        tick();
        respond(64'hAABB_CC00_0000_0000);
`ifdef MEMLOAD_SPLIT_EN
        check("t3_valid1", {63'd0, mem_bus.mem_req_valid}, 64'd1);
        check("t3_addr1", mem_bus.mem_req_addr, 64'h3008);
        tick();
        respond(64'h0000_0000_00DD_EEFF);
        check("t3_early_done", {63'd0, load_done}, 64'd0);
        tick();
        check("t3_done", {63'd0, load_done}, 64'd1);
        check("t3_buf", load_buffer, 64'h0000_DDEE_FFAA_BBCC);
        exp_buf = 64'h0000_DDEE_FFAA_BBCC;
`else
        check("t3_no_req1", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        tick();
        check("t3_fault", {63'd0, ld_fault}, 64'd1);
        check("t3_no_done", {63'd0, load_done}, 64'd0);
        check("t3_buf_hold", load_buffer, exp_buf);
        tick();
        check("t3_fault_pulse", {63'd0, ld_fault}, 64'd0);
`endif
        tick();

        // 2B signed at 0x4002 with ready held low for four edges
        mem_bus.mem_req_ready = 1'b0;
        start(64'h4002, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t4_valid_hold", {63'd0, mem_bus.mem_req_valid}, 64'd1);
            check("t4_addr_hold", mem_bus.mem_req_addr, 64'h4000);
            tick();
        end
        check("t4_valid_last", {63'd0, mem_bus.mem_req_valid}, 64'd1);
        mem_bus.mem_req_ready = 1'b1;
        tick();
        respond(64'h0000_0000_8001_0000);
        check("t4_early_done", {63'd0, load_done}, 64'd0);
        tick();
        check("t4_done", {63'd0, load_done}, 64'd1);
        check("t4_buf", load_buffer, 64'hFFFF_FFFF_FFFF_8001);
        exp_buf = 64'hFFFF_FFFF_FFFF_8001;
        tick();

        // flush in WAIT0: drain one late response, then a clean load
        start(64'h5000, 2'd0, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_drain_busy", {63'd0, ld_busy}, 64'd1);
        tick();
        check("t5_still_drain", {63'd0, ld_busy}, 64'd1);
        respond(64'h0000_0000_0000_0077);
        check("t5_idle", {63'd0, ld_busy}, 64'd0);
        check("t5_no_done", {63'd0, load_done}, 64'd0);
        check("t5_buf_hold", load_buffer, exp_buf);
        start(64'h6000, 2'd3, 1'b1);
        tick();
        respond(64'h0123_4567_89AB_CDEF);
        tick();
        check("t5_new_done", {63'd0, load_done}, 64'd1);
        check("t5_new_buf", load_buffer, 64'h0123_4567_89AB_CDEF);
        exp_buf = 64'h0123_4567_89AB_CDEF;
        tick();

        // flush in REQ0: back to IDLE on the next edge
        start(64'h7000, 2'd0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_idle", {63'd0, ld_busy}, 64'd0);
        check("t6_valid", {63'd0, mem_bus.mem_req_valid}, 64'd0);
        respond(64'h0000_0000_0000_0011);
        tick();
        check("t6_no_done", {63'd0, load_done}, 64'd0);
        check("t6_buf_hold", load_buffer, exp_buf);

        // flush with ld_start in IDLE drops the start
        flush = 1'b1;
        start(64'h8000, 2'd0, 1'b0);
        flush = 1'b0;
        check("t7_dropped", {63'd0, ld_busy}, 64'd0);

        // flush with response in WAIT0 goes straight to IDLE
        start(64'h9000, 2'd0, 1'b0);
        tick();
        flush = 1'b1;
        respond(64'h0000_0000_0000_0022);
        flush = 1'b0;
        check("t8_idle", {63'd0, ld_busy}, 64'd0);
        tick();
        check("t8_no_done", {63'd0, load_done}, 64'd0);
        check("t8_buf_hold", load_buffer, exp_buf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mod_memload.md
# mod_memload

Load unit for the memory stage of the x86-64 pipeline. It accepts a load request (address, size, signedness) from the memory stage and issues one or two 8-byte-aligned reads on the data-memory port. It merges and extracts the addressed bytes and returns a sign- or zero-extended 64-bit value with a one-cycle `load_done` pulse. The memory stage consumes `load_done` and `load_buffer` to release the MEM/EX handoff.

## Interface
Parameters:
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: memory port data width; fixed at 8 bytes.

Ports (reset is synchronous and active-low):
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `ld_start` in 1: load request; sampled only in IDLE.
- `ld_addr` in 64: byte address of the load.
- `ld_size` in 2: access size. 0=1B, 1=2B, 2=4B, 3=8B.
- `ld_signed` in 1: 1 = sign-extend the result, 0 = zero-extend.
- `flush` in 1: abandon the current load.
- `ld_busy` out 1: high in any state other than IDLE.
- `load_done` out 1: one-cycle pulse; result valid.
- `load_buffer` out 64: extended load result; held until the next `load_done`.
- `ld_fault` out 1: one-cycle pulse in place of `load_done` when a load is unsupported.
- `mem_req_valid` out 1: read request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out 64: read address; low 3 bits always 0.
- `mem_resp_valid` in 1: read data valid. Responses arrive in request order, at most one per request.
- `mem_resp_data` in 64: read data. Byte k = bits of weight 2^(8k)..2^(8k+7) (little-endian).

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN.
- IDLE:
  - `ld_start`=1 latches addr/size/signed and computes `off` = addr[2:0] and `nbytes` = 1<<size.
  - Next state is REQ0.
- REQ0: `mem_req_valid`=1, `mem_req_addr` = addr with the low 3 bits cleared. On `mem_req_ready`, go to WAIT0.
- WAIT0: on `mem_resp_valid`, capture the data into `q0`.
  - If `off`+`nbytes` ≤ 8, go to DONE.
  - Otherwise the load crosses into the next quadword; go to REQ1.
- REQ1/WAIT1: request the aligned address + 8 (the 64-bit add wraps to 0), then capture the response into `q1`. Next state is DONE.
- DONE:
  - Form the 128-bit value {q1,q0}, shift right by 8·`off`, and keep the low `nbytes` bytes.
  - Sign-extend from bit 8·nbytes−1 when `ld_signed`=1; otherwise zero-extend.
  - Register the result into `load_buffer` and pulse `load_done`. Next state is IDLE.
- `ld_start` while busy is ignored; there is no queueing.
- `mem_resp_valid` in IDLE/REQx/DONE is ignored.
- `flush`:
  - In REQ0/REQ1 the request is dropped and the state goes to IDLE.
  - In WAIT0/WAIT1 the state goes to DRAIN; DRAIN absorbs exactly one response, then goes to IDLE.
  - In DONE the pulse is suppressed and `load_buffer` is unchanged.
  - `flush` and `ld_start` in the same IDLE cycle: `flush` wins and the start is dropped.
- `flush` wins over `mem_resp_valid` in the same WAIT cycle: the response counts as drained, and the state goes directly to IDLE.

## Timing
- Reset values: all outputs 0, `load_buffer`=0, state IDLE.
- Reset mid-operation returns to IDLE at once. Draining an in-flight memory response after reset is the memory side's responsibility.
- Latency with ready=1 and the response on the cycle after the request:
  - Single-quadword load: `ld_start` at cycle N, request at N+1, response at N+2, `load_done` at N+3.
  - Split load: `load_done` at N+5.
- `mem_req_valid`/`mem_req_addr` come from registers and stay stable until `mem_req_ready`.

## Configuration
- `MEMLOAD_SPLIT_EN` defined: quadword-crossing loads are handled by REQ1/WAIT1 as above.
- Not defined:
  - REQ1/WAIT1 are not built.
  - A crossing load goes from WAIT0 to DONE, which pulses `ld_fault` instead of `load_done` and leaves `load_buffer` unchanged.
  - The non-crossing path is unchanged.

## Structure
- Package `memload_pkg`:
  - `ld_size_t` enum (B1/B2/B4/B8).
  - `memload_state_t` enum.
  - `QWORD_BYTES`=8 constant.
- One sub-module, `mod_load_align`: combinational extract/shift/extend from {q1,q0}, `off`, `size`, `signed` to 64 bits. The FSM and registers stay in `mod_memload`.

## Test plan
- 1B signed load at 0x1007, q0 = 0x80_00000000000000 → `load_buffer` = 0xFFFFFFFFFFFFFF80, `load_done` at N+3.
- 4B unsigned load at 0x2004, q0 = 0xDEADBEEF_11223344 → 0x00000000DEADBEEF, with one request to 0x2000.
- 8B load at 0x3005, q0 = 0xAABBCC0000000000, q1 = 0x0000000000DDEEFF, with split enabled:
  - Requests go to 0x3000, then 0x3008.
  - Result = 0xDDEEFFAABBCC… (bytes 5..12 of {q1,q0}); `load_done` at N+5.
- Same 8B crossing load with the macro undefined → `ld_fault` pulse, no second request, `load_buffer` unchanged.
- `mem_req_ready` held low 4 cycles → request valid and address stable throughout; `load_done` is delayed by 4 cycles.
- Two flush cases:
  - `flush` in WAIT0 → DRAIN; one late response is absorbed with no `load_done`, then a new `ld_start` completes normally.
  - `flush` in REQ0 → IDLE next cycle.
